// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core load/store
// path (port 0) and the loader/debug port (port 1). Round-robin arbitration,
// bounded lock for atomic sequences, 1-cycle read return routed to the issuer.
module dmem_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int DMEM_SZ_IN_KB = 1,
    parameter int LOCK_MAX      = 8,
    localparam int ADDR_WIDTH   = $clog2(DMEM_SZ_IN_KB * 1024)
) (
    input  logic                  clk,
    input  logic                  arst,
    // port 0: core load/store path
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic                  m0_lock,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    // port 1: loader/debug port
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic                  m1_lock,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    // dmem side
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

    logic             last;         // port granted most recently
    logic             owner_valid;  // a lock is held
    logic             owner;        // port holding the lock
    logic [CNT_W-1:0] lock_cnt;     // locked grants taken so far
    logic             rd_pend;      // read issued last cycle
    logic             rd_port;      // port that issued it

    logic gnt0, gnt1;
    logic gnt_lock;
    logic lock_active;

    // An exhausted lock no longer restricts arbitration; it is dropped at the
    // end of this cycle whether or not the owner is granted.
    assign lock_active = owner_valid && (lock_cnt != CNT_MAX);
    assign gnt_lock    = gnt1 ? m1_lock : m0_lock;

    // Grant selection: lock owner first, otherwise round-robin against last.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!arst) begin
            if (lock_active) begin
                gnt0 = m0_req && !owner;
                gnt1 = m1_req &&  owner;
            end else if (m0_req && m1_req) begin
                gnt0 =  last;
                gnt1 = !last;
            end else begin
                gnt0 = m0_req;
                gnt1 = m1_req;
            end
        end
    end

    assign m0_gnt = gnt0;
    assign m1_gnt = gnt1;
    assign mem_en = gnt0 | gnt1;

    // Memory command mux from the granted port; all zero when idle.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (gnt1) begin
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    // Arbiter history and lock bookkeeping.
    always_ff @(posedge clk or posedge arst) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (arst) begin
            last        <= 1'b1;
            owner_valid <= 1'b0;
            owner       <= 1'b0;
            lock_cnt    <= '0;
        end else if (mem_en) begin
            last <= gnt1;
            if (lock_active) begin
                // Only the owner can be granted here.
                if (gnt_lock) begin
                    lock_cnt <= lock_cnt + 1'b1;
                end else begin
                    owner_valid <= 1'b0;
                    lock_cnt    <= '0;
                end
            end else if (gnt_lock && !(owner_valid && owner == gnt1)) begin
                owner_valid <= 1'b1;
                owner       <= gnt1;
                lock_cnt    <= CNT_W'(1);
            end else begin
                // Unlocked grant, or the exhausted owner's final access.
                owner_valid <= 1'b0;
                lock_cnt    <= '0;
            end
        end else if (owner_valid && !lock_active) begin
            owner_valid <= 1'b0;
            lock_cnt    <= '0;
        end
    end

    // Remember which port issued a read so its data can be returned next cycle.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rd_pend <= 1'b0;
            rd_port <= 1'b0;
        end else begin
            rd_pend <= mem_en && !mem_we;
            if (mem_en) begin
                rd_port <= gnt1;
            end
        end
    end

    // Read return routing; the non-issuing port sees zero data.
    always_comb begin
        m0_rvalid = rd_pend && !rd_port;
        m1_rvalid = rd_pend &&  rd_port;
        m0_rdata  = m0_rvalid ? mem_rdata : '0;
        m1_rdata  = m1_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus randomized traffic,
// checked each cycle against a behavioural model of the arbitration rules.
module tb_dmem_arbiter;

    localparam int DATA_WIDTH    = 32;
    localparam int DMEM_SZ_IN_KB = 1;
    localparam int ADDR_WIDTH    = $clog2(DMEM_SZ_IN_KB * 1024);
    localparam int LOCK_MAX      = 8;
    localparam int DEPTH         = 1 << ADDR_WIDTH;

    typedef struct packed {
        logic                  req;
        logic                  we;
        logic                  lock;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    logic clk  = 1'b0;
    logic arst = 1'b1;
    req_t drv [2];

    logic                  m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [DATA_WIDTH-1:0] m0_rdata, m1_rdata;
    logic                  mem_en, mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata = '0;

    dmem_arbiter #(
        .DATA_WIDTH(DATA_WIDTH), .DMEM_SZ_IN_KB(DMEM_SZ_IN_KB), .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clk(clk), .arst(arst),
        .m0_req(drv[0].req), .m0_we(drv[0].we), .m0_lock(drv[0].lock),
        .m0_addr(drv[0].addr), .m0_wdata(drv[0].wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(drv[1].req), .m1_we(drv[1].we), .m1_lock(drv[1].lock),
        .m1_addr(drv[1].addr), .m1_wdata(drv[1].wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous dmem attached to the DUT.
    logic [DATA_WIDTH-1:0] dmem [DEPTH] = '{default: '0};
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) dmem[mem_addr] <= mem_wdata;
            else        mem_rdata      <= dmem[mem_addr];
        end
    end

    // Reference model state.
    logic [DATA_WIDTH-1:0] gold [DEPTH] = '{default: '0};
    int                    m_last, m_owner, m_cnt;
    bit                    m_ov;
    bit                    e_rv;
    int                    e_rport;
    logic [DATA_WIDTH-1:0] e_rdata;

    // DUT values sampled by the last tick.
    logic                  r_gnt0, r_gnt1, r_rv0, r_rv1;
    logic [DATA_WIDTH-1:0] r_rd0, r_rd1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [DATA_WIDTH-1:0] act,
                         input logic [DATA_WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Lock still binding: held and fewer than LOCK_MAX locked grants taken.
    function automatic bit lock_binding();
        return m_ov && (m_cnt < LOCK_MAX);
    endfunction

    // Which port must be granted this cycle (-1 = none).
    function automatic int model_grant();
        if (lock_binding()) return drv[m_owner].req ? m_owner : -1;
        if (drv[0].req && drv[1].req) return (m_last == 0) ? 1 : 0;
        if (drv[0].req) return 0;
        if (drv[1].req) return 1;
        return -1;
    endfunction

    task automatic set_port(input int p, input logic req, input logic we, input logic lock,
                            input logic [ADDR_WIDTH-1:0] addr,
                            input logic [DATA_WIDTH-1:0] wdata);
        drv[p].req   = req;
        drv[p].we    = we;
        drv[p].lock  = lock;
        drv[p].addr  = addr;
        drv[p].wdata = wdata;
    endtask

    // One clock cycle: compare every output against the model at the falling
    // edge, then advance the model to what the next rising edge produces.
    task automatic tick();
        int                    g;
        logic                  x_we;
        logic [ADDR_WIDTH-1:0] x_addr;
        logic [DATA_WIDTH-1:0] x_wdata;
        @(negedge clk);
        g       = model_grant();
        x_we    = (g >= 0) ? drv[g].we    : 1'b0;
        x_addr  = (g >= 0) ? drv[g].addr  : '0;
        x_wdata = (g >= 0) ? drv[g].wdata : '0;
        check1("m0_gnt", m0_gnt, g == 0);
        check1("m1_gnt", m1_gnt, g == 1);
        check1("mem_en", mem_en, g >= 0);
        check1("mem_we", mem_we, x_we);
        check("mem_addr", 32'(mem_addr), 32'(x_addr));
        check("mem_wdata", mem_wdata, x_wdata);
        check1("m0_rvalid", m0_rvalid, e_rv && e_rport == 0);
        check1("m1_rvalid", m1_rvalid, e_rv && e_rport == 1);
        check("m0_rdata", m0_rdata, (e_rv && e_rport == 0) ? e_rdata : '0);
        check("m1_rdata", m1_rdata, (e_rv && e_rport == 1) ? e_rdata : '0);
        r_gnt0 = m0_gnt; r_gnt1 = m1_gnt;
        r_rv0  = m0_rvalid; r_rv1 = m1_rvalid;
        r_rd0  = m0_rdata;  r_rd1 = m1_rdata;

        e_rv = 0;
        if (g >= 0) begin
            if (drv[g].we) begin
                gold[drv[g].addr] = drv[g].wdata;
            end else begin
                e_rv    = 1;
                e_rport = g;
                e_rdata = gold[drv[g].addr];
            end
            if (lock_binding()) begin
                if (drv[g].lock) m_cnt++;
                else begin m_ov = 0; m_cnt = 0; end
            end else if (drv[g].lock && !(m_ov && m_owner == g)) begin
                m_ov = 1; m_owner = g; m_cnt = 1;
            end else begin
                m_ov = 0; m_cnt = 0;
            end
            m_last = g;
        end else if (m_ov && m_cnt >= LOCK_MAX) begin
            m_ov = 0; m_cnt = 0;
        end
        @(posedge clk);
        #1;
    endtask

    // Assert reset mid-cycle with requests still raised; everything must read 0.
    task automatic do_reset();
        arst = 1'b1;
        @(negedge clk);
        check1("rst m0_gnt", m0_gnt, 1'b0);
        check1("rst m1_gnt", m1_gnt, 1'b0);
        check1("rst m0_rvalid", m0_rvalid, 1'b0);
        check1("rst m1_rvalid", m1_rvalid, 1'b0);
        check("rst m0_rdata", m0_rdata, '0);
        check("rst m1_rdata", m1_rdata, '0);
        check1("rst mem_en", mem_en, 1'b0);
        check1("rst mem_we", mem_we, 1'b0);
        check("rst mem_addr", 32'(mem_addr), '0);
        check("rst mem_wdata", mem_wdata, '0);
        arst = 1'b0;
        set_port(0, 0, 0, 0, '0, '0);
        set_port(1, 0, 0, 0, '0, '0);
        m_last = 1; m_ov = 0; m_owner = 0; m_cnt = 0; e_rv = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] seq0, seq_rv0, seq_rv1;
        int         c0, c1;
        bit         m1_won;

        set_port(0, 0, 0, 0, '0, '0);
        set_port(1, 0, 0, 0, '0, '0);
        @(posedge clk);
        #1;
        do_reset();

        // Single port: write then read back through port 0.
        set_port(0, 1, 1, 0, 10'h10, 32'hDEADBEEF);
        tick();
        check1("sp write gnt", r_gnt0, 1'b1);
        set_port(0, 1, 0, 0, 10'h10, '0);
        tick();
        check1("sp read gnt", r_gnt0, 1'b1);
        set_port(0, 0, 0, 0, '0, '0);
        tick();
        check1("sp rvalid", r_rv0, 1'b1);
        check("sp rdata", r_rd0, 32'hDEADBEEF);
        check1("sp m1_rvalid", r_rv1, 1'b0);

        // Locked read by port 1 left pending, then reset on top of it.
        set_port(1, 1, 0, 1, 10'h20, '0);
        tick();
        set_port(0, 1, 0, 0, 10'h10, '0);
        do_reset();

        // Round-robin: both ports read every cycle.
        seq0 = '0; seq_rv0 = '0; seq_rv1 = '0;
        for (int i = 0; i < 6; i++) begin
            set_port(0, 1, 0, 0, 10'h10, '0);
            set_port(1, 1, 0, 0, 10'h21, '0);
            tick();
            seq0[i]    = r_gnt0;
            seq_rv0[i] = r_rv0;
            seq_rv1[i] = r_rv1;
            if (i == 0) check1("rr no rvalid after reset", r_rv0 | r_rv1, 1'b0);
            if (i == 1) check("rr first rdata", r_rd0, 32'hDEADBEEF);
        end
        check("rr grant order", 32'(seq0), 32'(6'b010101));
        check("rr m0 rvalid order", 32'(seq_rv0), 32'(6'b101010));
        check("rr m1 rvalid order", 32'(seq_rv1), 32'(6'b010100));
        set_port(0, 0, 0, 0, '0, '0);
        set_port(1, 0, 0, 0, '0, '0);
        tick();

        // Lock: port 1 takes 3 locked accesses and an unlocking one.
        set_port(0, 1, 1, 0, 10'h30, 32'h1111);
        tick();
        set_port(0, 1, 1, 0, 10'h31, 32'h2222);
        c0 = 0; c1 = 0;
        for (int i = 0; i < 4; i++) begin
            set_port(1, 1, 1, (i < 3) ? 1'b1 : 1'b0, 10'(10'h40 + i), 32'(i));
            tick();
            c0 += int'(r_gnt0);
            c1 += int'(r_gnt1);
        end
        check("lock m0 grants", 32'(c0), 32'd0);
        check("lock m1 grants", 32'(c1), 32'd4);
        set_port(1, 0, 0, 0, '0, '0);
        tick();
        check1("lock m0 after release", r_gnt0, 1'b1);
        set_port(0, 0, 0, 0, '0, '0);

        // Forced release after LOCK_MAX locked grants.
        set_port(0, 1, 1, 1, 10'h50, 32'h5555);
        tick();
        c0 = int'(r_gnt0);
        m1_won = 0;
        set_port(1, 1, 1, 0, 10'h51, 32'h6666);
        for (int i = 0; i < 12 && !m1_won; i++) begin
            tick();
            c0 += int'(r_gnt0);
            m1_won = r_gnt1;
        end
        check("forced m0 grants", 32'(c0), 32'(LOCK_MAX));
        check1("forced m1 granted", m1_won, 1'b1);
        set_port(0, 0, 0, 0, '0, '0);
        set_port(1, 0, 0, 0, '0, '0);
        tick();

        // Idle owner keeps port 1 out until it unlocks.
        set_port(0, 1, 1, 1, 10'h60, 32'h7777);
        tick();
        check1("idle lock gnt", r_gnt0, 1'b1);
        set_port(0, 0, 0, 0, '0, '0);
        set_port(1, 1, 1, 0, 10'h61, 32'h8888);
        c1 = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            c1 += int'(r_gnt1);
        end
        check("idle m1 grants", 32'(c1), 32'd0);
        set_port(0, 1, 1, 0, 10'h62, 32'h9999);
        tick();
        check1("idle unlock m0", r_gnt0, 1'b1);
        set_port(0, 0, 0, 0, '0, '0);
        tick();
        check1("idle m1 next", r_gnt1, 1'b1);
        set_port(1, 0, 0, 0, '0, '0);
        tick();

        // Randomized traffic; each request is held until granted.
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                do_reset();
            end else begin
                for (int p = 0; p < 2; p++) begin
                    if (!drv[p].req || (p == 0 ? r_gnt0 : r_gnt1)) begin
                        if ($urandom_range(0, 9) < 6)
                            set_port(p, 1, 1'($urandom_range(0, 1)),
                                     1'($urandom_range(0, 3) == 0),
                                     10'($urandom_range(0, 15)), $urandom);
                        else
                            set_port(p, 0, 0, 0, '0, '0);
                    end
                end
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
